ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and execute-stage operand selector for the pipelined ARM CPU. It captures decoded operands and control from ID and returns the registered source-register numbers to the forwarding unit. Using the forwarding unit's ForwardA/ForwardB/ForwardFlags codes, it drives the final ALU operands and the store data. It also owns the architectural NZCV flag register and supplies branch-resolution flags with MEM-stage flag forwarding applied.

## Interface
Parameters:
- WIDTH, 64, datapath width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold ID/EX contents (load-use hazard).
- flush  in  1  load a bubble into ID/EX (branch taken / hazard bubble).
- id_opcode  in  32  instruction word in ID.
- id_rdata1, id_rdata2  in  WIDTH  register-file read data.
- id_imm  in  WIDTH  sign/zero-extended immediate.
- id_use_imm  in  1  operand B takes the immediate.
- id_regwrite, id_setflags  in  1  control from decode.
- id_src1, id_src2  in  5  source register numbers (Rn, Rm/Rt).
- ForwardA, ForwardB  in  2  00 = ID/EX, 10 = EX/MEM, 01 = MEM/WB; 11 is treated as 00.
- ForwardFlags  in  1  use MEM-stage flags for branch.
- mem_alu_result  in  WIDTH  EX/MEM result.
- wb_result  in  WIDTH  MEM/WB write-back value.
- mem_setflags  in  1  instruction in MEM sets flags.
- mem_flags  in  4  NZCV computed by that instruction.
- ex_opcode  out  32; ex_regwrite, ex_setflags  out  1; ex_src1, ex_src2  out  5  registered ID/EX fields.
- ex_opA, ex_opB  out  WIDTH  forwarded ALU operands.
- ex_store_data  out  WIDTH  forwarded rdata2, taken before the immediate mux.
- flags  out  4  architectural NZCV register.
- branch_flags  out  4  flags for conditional branch (B.cond/BLT).
- bubble_count  out  16  saturating count of inserted bubbles.

## Operation
- Reset, highest priority: all ID/EX fields are 0. This includes opcode, regwrite, setflags, src regs, data, imm and use_imm. flags = 4'b0000, bubble_count = 0.
- Flush, next priority: ID/EX loads a bubble. opcode = 32'h0, regwrite = 0, setflags = 0, use_imm = 0, data = 0. src1 and src2 = 5'd31 so that no forwarding can match. bubble_count increments.
- Stall without flush: all ID/EX fields hold their values and bubble_count holds.
- Otherwise: all id_* fields are captured.
- When flush and stall are both asserted, flush wins.
- Operand A: ForwardA = 10 selects mem_alu_result, 01 selects wb_result, anything else selects the registered rdata1.
- Forwarded B (fwdB) uses the same selection on ForwardB against the registered rdata2.
- ex_store_data = fwdB.
- ex_opB = registered use_imm ? registered imm : fwdB. The immediate always bypasses forwarding.
- Flag register: when mem_setflags = 1, flags <= mem_flags on the clock edge, independent of stall and flush.
- branch_flags = ForwardFlags ? mem_flags : flags. This path is combinational.
- bubble_count saturates at 16'hFFFF and does not wrap.

## Timing
- ID to ex_* fields: 1-cycle latency, registered.
- ex_opA, ex_opB, ex_store_data and branch_flags are combinational from registered state and same-cycle forward inputs. There are no added cycles.
- ex_src1 and ex_src2 are valid from the clock edge onward, so the forwarding unit closes its loop within the same cycle.
- A flags write becomes visible on `flags` in the cycle after mem_setflags. branch_flags sees mem_flags in the same cycle when ForwardFlags = 1.
- Reset mid-stall: the stall is abandoned and the outputs take their reset values on the next edge.

## Test plan
- Reset, then capture: drive reset 1 for 2 cycles and check all outputs 0. Then present id_rdata1 = 5, id_rdata2 = 7, id_use_imm = 0, ForwardA/B = 00. One cycle later, check ex_opA = 5, ex_opB = 7, ex_store_data = 7.
- Forwarding priority and codes, with registered rdata1 = 1 and rdata2 = 2:
  - ForwardA = 10 with mem_alu_result = 100 gives ex_opA = 100.
  - ForwardB = 01 with wb_result = 200 gives ex_opB = 200.
  - ForwardA = 11 gives ex_opA = 1.
- Immediate bypass: use_imm = 1, imm = 0x10, ForwardB = 10, mem_alu_result = 0x99. Check ex_opB = 0x10 and ex_store_data = 0x99.
- Stall/flush:
  - Stall 3 cycles while id_* changes; ex_* stays constant.
  - Flush and stall together give a bubble: ex_regwrite = 0, ex_src1 = ex_src2 = 31, bubble_count = 1.
- Flags:
  - mem_setflags = 1, mem_flags = 4'b1000 gives flags = 1000 next cycle.
  - ForwardFlags = 1 with mem_flags = 0100 gives branch_flags = 0100 in the same cycle while flags is still 1000.
- Saturation: 65540 consecutive flushes leave bubble_count = 16'hFFFF.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register plus execute-stage operand forwarding, NZCV flag register and branch flags.
// ex_* fields land one cycle after ID; operand and branch-flag muxes are combinational; stall holds, flush bubbles.
module ex_operand_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [31:0]      id_opcode,
   input  logic [WIDTH-1:0] id_rdata1,
   input  logic [WIDTH-1:0] id_rdata2,
   input  logic [WIDTH-1:0] id_imm,
   input  logic             id_use_imm,
   input  logic             id_regwrite,
   input  logic             id_setflags,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic [1:0]       ForwardA,
   input  logic [1:0]       ForwardB,
   input  logic             ForwardFlags,
   input  logic [WIDTH-1:0] mem_alu_result,
   input  logic [WIDTH-1:0] wb_result,
   input  logic             mem_setflags,
   input  logic [3:0]       mem_flags,
   output logic [31:0]      ex_opcode,
   output logic             ex_regwrite,
   output logic             ex_setflags,
   output logic [4:0]       ex_src1,
   output logic [4:0]       ex_src2,
   output logic [WIDTH-1:0] ex_opA,
   output logic [WIDTH-1:0] ex_opB,
   output logic [WIDTH-1:0] ex_store_data,
   output logic [3:0]       flags,
   output logic [3:0]       branch_flags,
   output logic [15:0]      bubble_count
);

   typedef struct packed {
      logic [31:0]      opcode;
      logic             regwrite;
      logic             setflags;
      logic             use_imm;
      logic [4:0]       src1;
      logic [4:0]       src2;
      logic [WIDTH-1:0] rdata1;
      logic [WIDTH-1:0] rdata2;
      logic [WIDTH-1:0] imm;
   } idex_t;

   localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

   idex_t idex_q;
   idex_t idex_capture;
   idex_t idex_bubble;
   logic [WIDTH-1:0] fwd_b;

   function automatic logic [WIDTH-1:0] fwd_sel(
      input logic [1:0]       sel,
      input logic [WIDTH-1:0] reg_val,
      input logic [WIDTH-1:0] mem_val,
      input logic [WIDTH-1:0] wb_val
   );
      logic [WIDTH-1:0] res;
      case (sel)
         2'b10:   res = mem_val;
         2'b01:   res = wb_val;
         default: res = reg_val;
      endcase
      return res;
   endfunction

   always_comb begin
      idex_capture          = '0;
      idex_capture.opcode   = id_opcode;
      idex_capture.regwrite = id_regwrite;
      idex_capture.setflags = id_setflags;
      idex_capture.use_imm  = id_use_imm;
      idex_capture.src1     = id_src1;
      idex_capture.src2     = id_src2;
      idex_capture.rdata1   = id_rdata1;
      idex_capture.rdata2   = id_rdata2;
      idex_capture.imm      = id_imm;
   end

   // Register 31 as the bubble's sources keeps the forwarding unit from matching a live destination.
   always_comb begin
      idex_bubble      = '0;
      idex_bubble.src1 = 5'd31;
      idex_bubble.src2 = 5'd31;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idex_q <= '0;
      end else if (flush) begin
         idex_q <= idex_bubble;
      end else if (!stall) begin
         idex_q <= idex_capture;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_count <= '0;
      end else if (flush && (bubble_count != BUBBLE_MAX)) begin
         bubble_count <= bubble_count + 16'd1;
      end
   end

   // Flag writes come from the instruction already in MEM, so ID/EX stall and flush do not gate them.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= 4'b0000;
      end else if (mem_setflags) begin
         flags <= mem_flags;
      end
   end

   assign ex_opcode   = idex_q.opcode;
   assign ex_regwrite = idex_q.regwrite;
   assign ex_setflags = idex_q.setflags;
   assign ex_src1     = idex_q.src1;
   assign ex_src2     = idex_q.src2;

   assign ex_opA        = fwd_sel(ForwardA, idex_q.rdata1, mem_alu_result, wb_result);
   assign fwd_b         = fwd_sel(ForwardB, idex_q.rdata2, mem_alu_result, wb_result);
   assign ex_store_data = fwd_b;
   assign ex_opB        = idex_q.use_imm ? idex_q.imm : fwd_b;

   assign branch_flags = ForwardFlags ? mem_flags : flags;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: reset, capture, forwarding codes, immediate bypass,
// stall/flush, flag register and forwarding, reset mid-stall, bubble counter saturation.
module tb_ex_operand_stage;

   localparam int WIDTH = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             stall;
   logic             flush;
   logic [31:0]      id_opcode;
   logic [WIDTH-1:0] id_rdata1;
   logic [WIDTH-1:0] id_rdata2;
   logic [WIDTH-1:0] id_imm;
   logic             id_use_imm;
   logic             id_regwrite;
   logic             id_setflags;
   logic [4:0]       id_src1;
   logic [4:0]       id_src2;
   logic [1:0]       ForwardA;
   logic [1:0]       ForwardB;
   logic             ForwardFlags;
   logic [WIDTH-1:0] mem_alu_result;
   logic [WIDTH-1:0] wb_result;
   logic             mem_setflags;
   logic [3:0]       mem_flags;
   logic [31:0]      ex_opcode;
   logic             ex_regwrite;
   logic             ex_setflags;
   logic [4:0]       ex_src1;
   logic [4:0]       ex_src2;
   logic [WIDTH-1:0] ex_opA;
   logic [WIDTH-1:0] ex_opB;
   logic [WIDTH-1:0] ex_store_data;
   logic [3:0]       flags;
   logic [3:0]       branch_flags;
   logic [15:0]      bubble_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_operand_stage #(.WIDTH(WIDTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .id_opcode      (id_opcode),
      .id_rdata1      (id_rdata1),
      .id_rdata2      (id_rdata2),
      .id_imm         (id_imm),
      .id_use_imm     (id_use_imm),
      .id_regwrite    (id_regwrite),
      .id_setflags    (id_setflags),
      .id_src1        (id_src1),
      .id_src2        (id_src2),
      .ForwardA       (ForwardA),
      .ForwardB       (ForwardB),
      .ForwardFlags   (ForwardFlags),
      .mem_alu_result (mem_alu_result),
      .wb_result      (wb_result),
      .mem_setflags   (mem_setflags),
      .mem_flags      (mem_flags),
      .ex_opcode      (ex_opcode),
      .ex_regwrite    (ex_regwrite),
      .ex_setflags    (ex_setflags),
      .ex_src1        (ex_src1),
      .ex_src2        (ex_src2),
      .ex_opA         (ex_opA),
      .ex_opB         (ex_opB),
      .ex_store_data  (ex_store_data),
      .flags          (flags),
      .branch_flags   (branch_flags),
      .bubble_count   (bubble_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge, well clear of the next sampling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      id_opcode = '0; id_rdata1 = '0; id_rdata2 = '0; id_imm = '0; id_use_imm = 1'b0;
      id_regwrite = 1'b0; id_setflags = 1'b0; id_src1 = '0; id_src2 = '0;
      ForwardA = 2'b00; ForwardB = 2'b00; ForwardFlags = 1'b0;
      mem_alu_result = '0; wb_result = '0; mem_setflags = 1'b0; mem_flags = 4'b0000;

      tick(); tick();
      chk("rst_opcode", ex_opcode, 0);
      chk("rst_regwrite", ex_regwrite, 0);
      chk("rst_setflags", ex_setflags, 0);
      chk("rst_src1", ex_src1, 0);
      chk("rst_src2", ex_src2, 0);
      chk("rst_opA", ex_opA, 0);
      chk("rst_opB", ex_opB, 0);
      chk("rst_store", ex_store_data, 0);
      chk("rst_flags", flags, 0);
      chk("rst_bflags", branch_flags, 0);
      chk("rst_bubbles", bubble_count, 0);

      // Plain capture
      reset = 1'b0;
      id_rdata1 = 64'd5; id_rdata2 = 64'd7; id_opcode = 32'hAABBCCDD;
      id_regwrite = 1'b1; id_setflags = 1'b1; id_src1 = 5'd3; id_src2 = 5'd4;
      chk("pre_cap_opA", ex_opA, 0);
      tick();
      chk("cap_opA", ex_opA, 5);
      chk("cap_opB", ex_opB, 7);
      chk("cap_store", ex_store_data, 7);
      chk("cap_opcode", ex_opcode, 32'hAABBCCDD);
      chk("cap_regwrite", ex_regwrite, 1);
      chk("cap_setflags", ex_setflags, 1);
      chk("cap_src1", ex_src1, 3);
      chk("cap_src2", ex_src2, 4);

      // Forwarding codes with registered rdata1=1, rdata2=2
      id_rdata1 = 64'd1; id_rdata2 = 64'd2;
      tick();
      ForwardA = 2'b10; mem_alu_result = 64'd100; wb_result = 64'd200;
      #1;
      chk("fwdA_mem", ex_opA, 100);
      chk("fwdA_mem_B_reg", ex_opB, 2);
      ForwardA = 2'b01;
      #1;
      chk("fwdA_wb", ex_opA, 200);
      ForwardA = 2'b00; ForwardB = 2'b01;
      #1;
      chk("fwdB_wb", ex_opB, 200);
      chk("fwdB_wb_store", ex_store_data, 200);
      chk("fwdA_reg", ex_opA, 1);
      ForwardB = 2'b10;
      #1;
      chk("fwdB_mem", ex_opB, 100);
      ForwardA = 2'b11; ForwardB = 2'b11;
      #1;
      chk("fwdA_11", ex_opA, 1);
      chk("fwdB_11", ex_opB, 2);

      // Immediate bypasses forwarding; store data still forwarded
      ForwardA = 2'b00; ForwardB = 2'b00;
      id_use_imm = 1'b1; id_imm = 64'h10;
      tick();
      ForwardB = 2'b10; mem_alu_result = 64'h99;
      #1;
      chk("imm_opB", ex_opB, 64'h10);
      chk("imm_store", ex_store_data, 64'h99);
      ForwardB = 2'b00;
      #1;
      chk("imm_store_reg", ex_store_data, 2);

      // Stall holds for 3 cycles while ID changes
      id_use_imm = 1'b0; id_opcode = 32'h11111111; id_rdata1 = 64'h55;
      id_src1 = 5'd9; id_src2 = 5'd10; id_regwrite = 1'b1;
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id_opcode = 32'h22220000 + 32'(i); id_rdata1 = 64'h700 + 64'(i);
         id_src1 = 5'(i + 20); id_regwrite = 1'b0;
         tick();
         chk("stall_opcode", ex_opcode, 32'h11111111);
         chk("stall_opA", ex_opA, 64'h55);
         chk("stall_src1", ex_src1, 9);
         chk("stall_regwrite", ex_regwrite, 1);
         chk("stall_bubbles", bubble_count, 0);
      end

      // Flush wins over stall
      flush = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      chk("bub_regwrite", ex_regwrite, 0);
      chk("bub_setflags", ex_setflags, 0);
      chk("bub_opcode", ex_opcode, 0);
      chk("bub_src1", ex_src1, 31);
      chk("bub_src2", ex_src2, 31);
      chk("bub_opA", ex_opA, 0);
      chk("bub_count", bubble_count, 1);
      tick();
      chk("post_bub_opcode", ex_opcode, 32'h22220002);
      chk("post_bub_count", bubble_count, 1);

      // Flag register and MEM-stage flag forwarding
      mem_setflags = 1'b1; mem_flags = 4'b1000;
      #1;
      chk("flags_before_edge", flags, 0);
      tick();
      chk("flags_written", flags, 4'b1000);
      mem_setflags = 1'b0; ForwardFlags = 1'b1; mem_flags = 4'b0100;
      #1;
      chk("bflags_fwd", branch_flags, 4'b0100);
      chk("flags_held", flags, 4'b1000);
      ForwardFlags = 1'b0;
      #1;
      chk("bflags_reg", branch_flags, 4'b1000);
      tick();
      chk("flags_no_write", flags, 4'b1000);
      // Flag write goes through during a stall
      stall = 1'b1; mem_setflags = 1'b1; mem_flags = 4'b0011;
      tick();
      chk("flags_in_stall", flags, 4'b0011);
      mem_setflags = 1'b0;

      // Reset while stalled
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_stall_opcode", ex_opcode, 0);
      chk("rst_stall_src1", ex_src1, 0);
      chk("rst_stall_flags", flags, 0);
      chk("rst_stall_bubbles", bubble_count, 0);
      stall = 1'b0;

      // Bubble counter saturation
      flush = 1'b1;
      repeat (65534) tick();
      chk("sat_fffe", bubble_count, 16'hFFFE);
      tick();
      chk("sat_ffff", bubble_count, 16'hFFFF);
      repeat (5) tick();
      flush = 1'b0;
      chk("sat_hold", bubble_count, 16'hFFFF);
      tick();
      chk("sat_after", bubble_count, 16'hFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
